// File: rtl/volume_accumulator_pkg.sv
// Shared definitions for the volume accumulator and the bar-scaling stage:
// sample/level widths, microphone zero code and FSM state encodings.
package volume_accumulator_pkg;

  localparam int SAMPLE_W = 12;
  localparam int LEVEL_W  = 20;
  localparam logic [SAMPLE_W-1:0] MID_LEVEL_DEFAULT = 12'd2048;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    UPDATE = 1'b1
  } state_t;

  // Ties return the first argument, so the fresh window sum wins on equality.
  function automatic logic [LEVEL_W-1:0] level_max(
    input logic [LEVEL_W-1:0] a,
    input logic [LEVEL_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/volume_accumulator_if.sv
// Sample input and held-level output bundle of the volume accumulator.
interface volume_accumulator_if;
  import volume_accumulator_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [LEVEL_W-1:0]  data;
  logic                data_valid;

  modport master (output sample_valid, output sample, input data, input data_valid);
  modport slave  (input sample_valid, input sample, output data, output data_valid);

endinterface

// File: rtl/volume_accumulator_abs_dev.sv
// Absolute distance of a microphone code from the zero-signal level.
module abs_dev
  import volume_accumulator_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] MID_LEVEL = MID_LEVEL_DEFAULT
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] dev
);

  // Fold the signed excursion around MID_LEVEL into a magnitude.
  always_comb begin
    dev = {SAMPLE_W{1'b0}};
    if (sample >= MID_LEVEL) begin
      dev = sample - MID_LEVEL;
    end else begin
      dev = MID_LEVEL - sample;
    end
  end

endmodule

// File: rtl/volume_accumulator.sv
// Windowed sum of sample deviations with a peak-hold level that decays
// by a fixed fraction each window.
module volume_accumulator
  import volume_accumulator_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] MID_LEVEL   = MID_LEVEL_DEFAULT,
  parameter int                  WINDOW_LOG2 = 8,
  parameter int                  DECAY_SHIFT = 3
) (
  input logic                 clk,
  input logic                 reset,
  volume_accumulator_if.slave bus
);

  state_t                   state;
  state_t                   next_state;
  logic [SAMPLE_W-1:0]      dev;
  logic [LEVEL_W-1:0]       dev_ext;
  logic [LEVEL_W-1:0]       acc;
  logic [WINDOW_LOG2-1:0]   counter;
  logic [LEVEL_W-1:0]       window_sum;
  logic [LEVEL_W-1:0]       level;
  logic                     level_valid;
  logic                     window_done;
  logic                     update_en;
  logic [LEVEL_W-1:0]       decayed;
  logic [LEVEL_W-1:0]       new_level;

  abs_dev #(.MID_LEVEL(MID_LEVEL)) u_abs_dev (
    .sample (bus.sample),
    .dev    (dev)
  );

  assign dev_ext     = {{(LEVEL_W-SAMPLE_W){1'b0}}, dev};
  assign window_done = bus.sample_valid && (counter == {WINDOW_LOG2{1'b1}});

  // State, accumulator and held-level registers; sampling runs in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCUM;
      acc         <= {LEVEL_W{1'b0}};
      counter     <= {WINDOW_LOG2{1'b0}};
      window_sum  <= {LEVEL_W{1'b0}};
      level       <= {LEVEL_W{1'b0}};
      level_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (bus.sample_valid) begin
        if (window_done) begin
          window_sum <= acc + dev_ext;
          acc        <= {LEVEL_W{1'b0}};
          counter    <= {WINDOW_LOG2{1'b0}};
        end else begin
          acc     <= acc + dev_ext;
          counter <= counter + WINDOW_LOG2'(1'b1);
        end
      end
      level_valid <= update_en;
      if (update_en) begin
        level <= new_level;
      end
    end
  end

  // Next-state: enter UPDATE on the window's last sample, stay one cycle.
  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   next_state = window_done ? UPDATE : ACCUM;
      UPDATE:  next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  // Output logic: decayed hold level, forced to zero once the shift term vanishes.
  always_comb begin
    update_en = (state == UPDATE);
    decayed   = {LEVEL_W{1'b0}};
    if ((level >> DECAY_SHIFT) == {LEVEL_W{1'b0}}) begin
      decayed = {LEVEL_W{1'b0}};
    end else begin
      decayed = level - (level >> DECAY_SHIFT);
    end
    new_level = level_max(window_sum, decayed);
  end

  assign bus.data       = level;
  assign bus.data_valid = level_valid;

endmodule

// File: tb/tb_volume_accumulator.sv
// Directed self-checking bench for volume_accumulator at default parameters.
module tb_volume_accumulator;

  logic clk = 1'b0;
  logic reset;

  volume_accumulator_if bus ();

  volume_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;
  int p0     = 0;
  int p_cyc  [8];
  logic [19:0] p_data [8];

  // Pulse monitor: records cycle stamp and level of every data_valid pulse.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.data_valid === 1'b1) begin
      pulses            <= pulses + 1;
      p_cyc[pulses % 8]  <= cyc;
      p_data[pulses % 8] <= bus.data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic feed(input int n, input logic [11:0] v);
    repeat (n) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample = v;
    end
  endtask

  // Expects no pulse after the last-sample edge, a pulse one edge later, then quiet.
  task automatic end_window(input string tag, input logic [19:0] exp);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check({tag, "_dv_early"}, 32'(bus.data_valid), 32'd0);
    @(negedge clk);
    check({tag, "_dv"}, 32'(bus.data_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.data), 32'(exp));
    @(negedge clk);
    check({tag, "_dv_late"}, 32'(bus.data_valid), 32'd0);
    check({tag, "_hold"}, 32'(bus.data), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample = 12'd0;
    repeat (3) begin
      @(negedge clk);
      check("rst_data", 32'(bus.data), 32'd0);
      check("rst_dv", 32'(bus.data_valid), 32'd0);
    end
    reset = 1'b0;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    check("post_rst_data", 32'(bus.data), 32'd0);
    check("post_rst_dv", 32'(bus.data_valid), 32'd0);
    #1 p0 = pulses;

    feed(256, 12'd2048); end_window("silent", 20'd0);
    feed(256, 12'd0);    end_window("full_scale", 20'h80000);
    feed(256, 12'd2048); end_window("decay_full", 20'd458752);
    repeat (50) @(negedge clk);
    check("idle_hold", 32'(bus.data), 32'd458752);
    check("idle_dv", 32'(bus.data_valid), 32'd0);
    #1 check("pulse_count_a", 32'(pulses - p0), 32'd3);

    apply_reset(1);
    @(negedge clk);
    check("rst_clears", 32'(bus.data), 32'd0);
    #1 p0 = pulses;
    feed(256, 12'd2148); end_window("dev100", 20'd25600);
    feed(256, 12'd2048); end_window("dev100_decay", 20'd22400);
    @(negedge clk);
    #1 check("pulse_count_b", 32'(pulses - p0), 32'd2);

    apply_reset(1);
    feed(1, 12'd2056); feed(255, 12'd2048); end_window("level8", 20'd8);
    feed(256, 12'd2048); end_window("decay8", 20'd7);
    feed(256, 12'd2048); end_window("floor", 20'd0);

    apply_reset(1);
    feed(100, 12'd4095);
    @(negedge clk);
    reset = 1'b1;
    check("partial_no_update", 32'(bus.data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.sample_valid = 1'b0;
    feed(256, 12'd2058); end_window("after_partial", 20'd2560);

    #1 p0 = pulses;
    feed(256, 12'd2148);
    @(negedge clk);
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("upd_rst_dv", 32'(bus.data_valid), 32'd0);
    check("upd_rst_data", 32'(bus.data), 32'd0);
    @(negedge clk);
    check("upd_rst_dv_late", 32'(bus.data_valid), 32'd0);
    #1 check("upd_rst_no_pulse", 32'(pulses - p0), 32'd0);

    apply_reset(1);
    #1 p0 = pulses;
    feed(256, 12'd2058);
    feed(256, 12'd2068);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("stream_pulses", 32'(pulses - p0), 32'd2);
    check("stream_first", 32'(p_data[p0 % 8]), 32'd2560);
    check("stream_second", 32'(p_data[(p0 + 1) % 8]), 32'd5120);
    check("stream_spacing", 32'(p_cyc[(p0 + 1) % 8] - p_cyc[p0 % 8]), 32'd256);
    check("stream_final", 32'(bus.data), 32'd5120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/volume_accumulator.md
VOLUME_ACCUMULATOR -- requirements
Module: volume_accumulator

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter MID_LEVEL, default 12'd2048: microphone zero-signal code.
REQ-003 Parameter WINDOW_LOG2, default 8: window length is 2^WINDOW_LOG2 accepted samples.
REQ-004 Parameter DECAY_SHIFT, default 3: per-window decay of the held level is held >> DECAY_SHIFT.
REQ-005 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  synchronous active-high reset.
REQ-007 Port sample_valid  input  1  qualifies sample for one clk cycle; may be high on any cycle, including back-to-back.
REQ-008 Port sample  input  12  unsigned microphone code.
REQ-009 Port data  output  20  held volume level, registered; feeds the bar-scaling stage directly.
REQ-010 Port data_valid  output  1  single-cycle pulse when data has just been updated.

Function
REQ-011 Deviation SHALL be dev = sample - MID_LEVEL if sample >= MID_LEVEL, else MID_LEVEL - sample; 12-bit unsigned, max 2048.
REQ-012 On each clk edge with sample_valid=1, dev SHALL be added to a 20-bit accumulator and an 8-bit (WINDOW_LOG2-bit) sample counter incremented.
REQ-013 Worst-case window sum is 2048*256 = 524288; the accumulator SHALL be 20 bits and SHALL never saturate or wrap at default parameters.
REQ-014 On the edge accepting the sample where counter = 2^WINDOW_LOG2-1: window_sum <= acc + dev, acc <= 0, counter wraps to 0, state ACCUM -> UPDATE.
REQ-015 State machine: two states, ACCUM (reset state) and UPDATE; UPDATE SHALL last exactly one cycle, then return to ACCUM.
REQ-016 Accumulation SHALL be independent of state: a sample accepted in the UPDATE cycle is the first sample of the next window; no sample is ever dropped.
REQ-017 On the edge leaving UPDATE: decayed = data - (data >> DECAY_SHIFT); data <= max(window_sum, decayed); data_valid <= 1.
REQ-018 When data < 2^DECAY_SHIFT, decayed SHALL be 0 (held level reaches 0 rather than sticking).
REQ-019 Equality (window_sum = decayed) SHALL select window_sum; result identical either way.
REQ-020 data_valid SHALL be 0 on every cycle other than the one following the UPDATE edge; latency from last-sample edge to data_valid high is 2 edges.
REQ-021 data SHALL hold its value between updates; sample_valid=0 for any duration SHALL not change data.

Reset
REQ-022 On reset=1 at a clk edge: data=0, data_valid=0, acc=0, counter=0, window_sum=0, state=ACCUM.
REQ-023 Reset mid-window SHALL discard the partial window; reset during UPDATE SHALL suppress that update and its data_valid pulse.
REQ-024 Reset SHALL take priority over a simultaneous sample_valid; that sample is discarded.

Structure
REQ-025 A shared header SHALL hold MID_LEVEL default, sample width 12, level width 20 and state encodings (ACCUM=0, UPDATE=1), shared with the bar-scaling stage.
REQ-026 Deviation logic SHALL be one combinational sub-module, abs_dev (12-bit in, 12-bit out); all other logic lives in volume_accumulator.

Verification
REQ-027 Reset asserted 3 cycles with sample_valid=1 -> data=0, data_valid=0 throughout and one cycle after release.
REQ-028 256 samples of 2048 -> data=0, one data_valid pulse 2 edges after last sample.
REQ-029 256 samples of 0 -> data=524288 (20'h80000); next 256 samples of 2048 -> data=458752.
REQ-030 256 samples of 2148 -> data=25600; then 256 samples of 2048 -> data=22400; data_valid pulses exactly twice.
REQ-031 100 samples of 4095, reset for 1 cycle, then 256 samples of 2058 -> data=2560 (partial window discarded).
REQ-032 sample_valid held high continuously, 256 samples of dev 10 then 256 of dev 20 -> data=2560 then 5120, pulses 256 cycles apart, no sample lost.
